bist_pattern_checker: RTL and testbench



---
 rtl/bist_pattern_checker.sv | 147 ++++++++++++++
 tb/tb_bist_pattern_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bist_pattern_checker.sv
// bist_pattern_checker: on-chip BIST engine. Drives LFSR stimulus into the user
// project inputs, compacts returned responses into a MISR signature and compares
// the final signature against a golden value.
// Optional build macro BIST_SIG_READ_EN exposes the live signature (sig_out)
// and the issued-vector count (vec_cnt).
module bist_pattern_checker #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      NUM_VECTORS = 255,
    parameter int unsigned      LATENCY     = 1,
    parameter logic [WIDTH-1:0] LFSR_SEED   = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] golden_sig,
    input  logic [WIDTH-1:0] resp_in,
    output logic [WIDTH-1:0] stim_out,
    output logic             stim_valid,
    output logic             busy,
    output logic             done,
    output logic             pass
`ifdef BIST_SIG_READ_EN
    ,
    output logic [WIDTH-1:0] sig_out,
    output logic [15:0]      vec_cnt
`endif
);

    // A zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [WIDTH-1:0] SEED       = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;
    localparam logic [15:0]      NUM_VEC_W  = 16'(NUM_VECTORS);
    localparam logic [3:0]       DRAIN_LAST = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_lfsr;
    logic [WIDTH-1:0]   r_misr;
    logic [15:0]        r_vec_cnt;
    logic [3:0]         r_drain_cnt;
    logic [LATENCY-1:0] r_vd;
    logic [WIDTH-1:0]   r_stim_out;
    logic               r_stim_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;

    logic [WIDTH-1:0]   w_lfsr_next;
    logic [WIDTH-1:0]   w_misr_next;
    logic               w_cap_en;
    logic               w_start_ok;

    // Polynomial x^8+x^6+x^5+x^4+1, Fibonacci form shifting left
    assign w_lfsr_next = {r_lfsr[WIDTH-2:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    assign w_misr_next = {r_misr[WIDTH-2:0], r_misr[7] ^ r_misr[5] ^ r_misr[4] ^ r_misr[3]} ^ resp_in;
    assign w_cap_en    = r_vd[LATENCY-1];
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // Run sequencing: stimulus issue, drain wait and result reporting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_lfsr       <= SEED;
            r_vec_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_stim_out   <= '0;
            r_stim_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_lfsr       <= SEED;
                        r_stim_out   <= SEED;
                        r_stim_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_pass       <= 1'b0;
                        r_vec_cnt    <= 16'd1;
                    end else if (r_state == S_DONE) begin
                        r_done <= 1'b1;
                        r_pass <= (r_misr == golden_sig);
                    end
                end
                S_RUN: begin
                    if (r_vec_cnt == NUM_VEC_W) begin
                        r_state      <= S_DRAIN;
                        r_stim_out   <= '0;
                        r_stim_valid <= 1'b0;
                        r_drain_cnt  <= '0;
                    end else begin
                        r_lfsr     <= w_lfsr_next;
                        r_stim_out <= w_lfsr_next;
                        r_vec_cnt  <= r_vec_cnt + 16'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == DRAIN_LAST) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 4'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Response capture: valid delay line aligns responses, MISR compacts them
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vd   <= '0;
            r_misr <= '0;
        end else begin
            r_vd[0] <= r_stim_valid;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_vd[i] <= r_vd[i-1];
            end
            if (w_start_ok) begin
                r_misr <= '0;
            end else if (w_cap_en) begin
                r_misr <= w_misr_next;
            end
        end
    end

    assign stim_out   = r_stim_out;
    assign stim_valid = r_stim_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign pass       = r_pass;

`ifdef BIST_SIG_READ_EN
    assign sig_out = r_misr;
    assign vec_cnt = r_vec_cnt;
`endif

endmodule

// File: tb/tb_bist_pattern_checker.sv
// Testbench for bist_pattern_checker: scoreboard of expected stimulus vectors
// plus signature/pass checks against a bench-side LFSR/MISR model.
module tb_bist_pattern_checker;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic       rst_a, start_a, loop_en;
    logic [7:0] golden_a, resp_a, resp_const_a, stim_a, r_loop;
    logic       valid_a, busy_a, done_a, pass_a;

    // Instance B: short run, long latency, zero seed
    logic       rst_b, start_b;
    logic [7:0] golden_b, resp_b, stim_b;
    logic       valid_b, busy_b, done_b, pass_b;

`ifdef BIST_SIG_READ_EN
    logic [7:0]  sig_a, sig_b;
    logic [15:0] cnt_a, cnt_b;
`endif

    // Loopback path: response is the stimulus delayed one cycle
    always_ff @(posedge clk) r_loop <= stim_a;
    assign resp_a = loop_en ? r_loop : resp_const_a;

    bist_pattern_checker u_dut_a (
        .clk        (clk),
        .rst        (rst_a),
        .start      (start_a),
        .golden_sig (golden_a),
        .resp_in    (resp_a),
        .stim_out   (stim_a),
        .stim_valid (valid_a),
        .busy       (busy_a),
        .done       (done_a),
        .pass       (pass_a)
`ifdef BIST_SIG_READ_EN
        ,
        .sig_out    (sig_a),
        .vec_cnt    (cnt_a)
`endif
    );

    bist_pattern_checker #(
        .NUM_VECTORS (4),
        .LATENCY     (3),
        .LFSR_SEED   (8'h00)
    ) u_dut_b (
        .clk        (clk),
        .rst        (rst_b),
        .start      (start_b),
        .golden_sig (golden_b),
        .resp_in    (resp_b),
        .stim_out   (stim_b),
        .stim_valid (valid_b),
        .busy       (busy_b),
        .done       (done_b),
        .pass       (pass_b)
`ifdef BIST_SIG_READ_EN
        ,
        .sig_out    (sig_b),
        .vec_cnt    (cnt_b)
`endif
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         n_vec_a = 0, n_vec_b = 0, n_busy_b = 0;
    int         t_bfall = 0, t_drise = 0;
    logic       prev_busy_b = 1'b0, prev_done_b = 1'b0;
    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [7:0] misr_step(input logic [7:0] m, input logic [7:0] r);
        return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]} ^ r;
    endfunction

    task automatic push_seq(input logic [7:0] seed, input int n, input bit to_b);
        logic [7:0] v;
        v = seed;
        for (int i = 0; i < n; i++) begin
            if (to_b) q_b.push_back(v);
            else      q_a.push_back(v);
            v = lfsr_next(v);
        end
    endtask

    // Advance one cycle and run the output monitors at the falling edge
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (valid_a) begin
            n_vec_a++;
            check_eq("stim_a_sb_nonempty", 32'(q_a.size() != 0), 32'd1);
            if (q_a.size() != 0) check_eq("stim_a", 32'(stim_a), 32'(q_a.pop_front()));
        end else begin
            check_eq("stim_a_idle", 32'(stim_a), 32'd0);
        end
        if (valid_b) begin
            n_vec_b++;
            check_eq("stim_b_sb_nonempty", 32'(q_b.size() != 0), 32'd1);
            if (q_b.size() != 0) check_eq("stim_b", 32'(stim_b), 32'(q_b.pop_front()));
        end
        if (busy_b) n_busy_b++;
        if (prev_busy_b && !busy_b) t_bfall = cyc;
        if (!prev_done_b && done_b) t_drise = cyc;
        prev_busy_b = busy_b;
        prev_done_b = done_b;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    // Wait for done on A, optionally pulsing start once mid-run
    task automatic wait_done_a(input int pulse_at, input int base);
        for (int i = 0; i < 1000; i++) begin
            tick();
            start_a = (pulse_at > 0) && ((n_vec_a - base) == pulse_at);
            if (done_a) break;
        end
        start_a = 1'b0;
        check_eq("done_a", 32'(done_a), 32'd1);
    endtask

    initial begin
        int         base;
        logic [7:0] sig;
        logic [7:0] v;

        rst_a = 1'b1; rst_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        golden_a = 8'h00; golden_b = 8'h00;
        resp_const_a = 8'h00; resp_b = 8'h00; loop_en = 1'b0;
        repeat (3) tick();
        check_eq("rst_valid_a", 32'(valid_a), 32'd0);
        check_eq("rst_busy_a",  32'(busy_a),  32'd0);
        check_eq("rst_done_a",  32'(done_a),  32'd0);
        check_eq("rst_pass_a",  32'(pass_a),  32'd0);
        check_eq("rst_stim_b",  32'(stim_b),  32'd0);
        check_eq("rst_busy_b",  32'(busy_b),  32'd0);
        rst_a = 1'b0; rst_b = 1'b0;
        tick();

        // Responses tied to 0: signature 00, golden 00 passes; start mid-run ignored
        base = n_vec_a;
        push_seq(8'h01, 255, 1'b0);
        pulse_start_a();
        wait_done_a(50, base);
        check_eq("pass_a_zero",   32'(pass_a), 32'd1);
        check_eq("vec_cnt_a",     32'(n_vec_a - base), 32'd255);
        check_eq("sb_a_drained",  32'(q_a.size()), 32'd0);
        golden_a = 8'h5A;
        tick();
        check_eq("pass_a_golden_live", 32'(pass_a), 32'd0);
        check_eq("done_a_hold",        32'(done_a), 32'd1);

        // Restart from DONE with golden 5A
        base = n_vec_a;
        push_seq(8'h01, 255, 1'b0);
        pulse_start_a();
        check_eq("restart_done_clr", 32'(done_a), 32'd0);
        check_eq("restart_pass_clr", 32'(pass_a), 32'd0);
        check_eq("restart_busy",     32'(busy_a), 32'd1);
        wait_done_a(0, base);
        check_eq("pass_a_5a", 32'(pass_a), 32'd0);

        // Loopback: signature of the full LFSR sequence
        sig = 8'h00;
        v = 8'h01;
        for (int i = 0; i < 255; i++) begin
            sig = misr_step(sig, v);
            v = lfsr_next(v);
        end
        loop_en  = 1'b1;
        golden_a = sig;
        base = n_vec_a;
        push_seq(8'h01, 255, 1'b0);
        pulse_start_a();
        wait_done_a(0, base);
        check_eq("pass_a_loop", 32'(pass_a), 32'd1);
        golden_a = sig ^ 8'h01;
        tick();
        check_eq("pass_a_loop_bad", 32'(pass_a), 32'd0);

        // Reset at vector 10, then a clean rerun from the seed
        golden_a = sig;
        base = n_vec_a;
        push_seq(8'h01, 255, 1'b0);
        pulse_start_a();
        for (int i = 0; i < 100; i++) begin
            if ((n_vec_a - base) == 10) break;
            tick();
        end
        check_eq("midrun_vec10", 32'(n_vec_a - base), 32'd10);
        rst_a = 1'b1;
        tick();
        check_eq("midrst_valid", 32'(valid_a), 32'd0);
        check_eq("midrst_stim",  32'(stim_a),  32'd0);
        check_eq("midrst_busy",  32'(busy_a),  32'd0);
        check_eq("midrst_done",  32'(done_a),  32'd0);
        check_eq("midrst_pass",  32'(pass_a),  32'd0);
        check_eq("midrst_left",  32'(q_a.size()), 32'd245);
        q_a.delete();
        rst_a = 1'b0;
        tick();
        base = n_vec_a;
        push_seq(8'h01, 255, 1'b0);
        pulse_start_a();
        wait_done_a(0, base);
        check_eq("pass_a_after_rst", 32'(pass_a), 32'd1);
        check_eq("vec_cnt_a_rerun",  32'(n_vec_a - base), 32'd255);

        // Short run: 4 vectors, latency 3, constant FF responses, zero seed
        sig = 8'h00;
        for (int i = 0; i < 4; i++) sig = misr_step(sig, 8'hFF);
        resp_b   = 8'hFF;
        golden_b = sig;
        base     = n_vec_b;
        n_busy_b = 0;
        push_seq(8'h01, 4, 1'b1);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_b) break;
            tick();
        end
        check_eq("done_b",        32'(done_b), 32'd1);
        check_eq("pass_b",        32'(pass_b), 32'd1);
        check_eq("busy_b_cycles", 32'(n_busy_b), 32'd7);
        check_eq("done_b_after_busy", 32'(t_drise - t_bfall), 32'd1);
        check_eq("vec_cnt_b",     32'(n_vec_b - base), 32'd4);
        check_eq("sb_b_drained",  32'(q_b.size()), 32'd0);
        golden_b = sig ^ 8'h01;
        tick();
        check_eq("pass_b_bad", 32'(pass_b), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
